// File: rtl/seq_alu_if.sv
// seq_alu_if: issue/result bundle between an operand source and seq_alu.
// The master side drives operands and opcode; the slave side (the ALU)
// answers with ready, a one-cycle result pulse, the held result and flags,
// and the 7-segment pattern.
interface seq_alu_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             error;
    logic             busy;
    logic [6:0]       seg;

    modport master (
        output in_valid, a, b, sel,
        input  in_ready, out_valid, result, zero, carry, overflow, error, busy, seg
    );

    modport slave (
        input  in_valid, a, b, sel,
        output in_ready, out_valid, result, zero, carry, overflow, error, busy, seg
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked, parametrised ALU with a valid/ready issue handshake.
// Single-cycle ops publish one cycle after accept. MULT (shift-add) and
// DIV (restoring) iterate one bit per cycle for WIDTH cycles, spend one
// cycle in DONE, and write the architectural HI/LO pair, which MFHI/MFLO read.
// Optional feature macro: SEQ_ALU_SEG_DISPLAY_EN adds a registered hex
// 7-segment decode of result[3:0]; without it seg is tied to zero.
// The WIDTH parameter must match the WIDTH of the connected interface.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_XOR  = 5'h04;
    localparam logic [4:0] OP_NOR  = 5'h05;
    localparam logic [4:0] OP_NAND = 5'h06;
    localparam logic [4:0] OP_XNOR = 5'h07;
    localparam logic [4:0] OP_EQU  = 5'h08;
    localparam logic [4:0] OP_GT   = 5'h09;
    localparam logic [4:0] OP_LT   = 5'h0A;
    localparam logic [4:0] OP_ROR  = 5'h0B;
    localparam logic [4:0] OP_ROL  = 5'h0C;
    localparam logic [4:0] OP_MULT = 5'h0D;
    localparam logic [4:0] OP_DIV  = 5'h0E;
    localparam logic [4:0] OP_MFLO = 5'h0F;
    localparam logic [4:0] OP_MFHI = 5'h10;

    localparam int               MSB       = WIDTH - 1;
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_e;

    state_e state;
    state_e state_next;

    logic               in_ready_c;
    logic               accept;
    logic               start_mul;
    logic               start_div;
    logic               last_step;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH-1:0]   rot_amt;
    logic [2*WIDTH-1:0] rot_pair;
    logic [2*WIDTH-1:0] ror_wide;
    logic [2*WIDTH-1:0] rol_wide;
    logic [WIDTH-1:0]   res_c;
    logic               carry_c;
    logic               ovf_c;
    logic               err_c;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic               publish;
    logic [WIDTH-1:0]   pub_result;
    logic               pub_carry;
    logic               pub_ovf;
    logic               pub_err;

    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               overflow_q;
    logic               error_q;

    // Next-state and ready: only IDLE accepts, MULT or nonzero-divisor DIV start iterating.
    always_comb begin
        state_next = state;
        in_ready_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (bus.sel == OP_MULT) begin
                        state_next = MUL;
                    end else if (bus.sel == OP_DIV && bus.b != '0) begin
                        state_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = bus.in_valid & in_ready_c;
    assign start_mul = accept && (bus.sel == OP_MULT);
    assign start_div = accept && (bus.sel == OP_DIV) && (bus.b != '0);
    assign last_step = (cnt == LAST_STEP);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Single-cycle result and flags, computed straight from the live operands.
    always_comb begin
        res_c    = '0;
        carry_c  = 1'b0;
        ovf_c    = 1'b0;
        err_c    = 1'b0;
        add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
        sub_diff = {1'b0, bus.a} - {1'b0, bus.b};
        rot_amt  = bus.b % WIDTH_VAL;
        rot_pair = {bus.a, bus.a};
        ror_wide = rot_pair >> rot_amt;
        rol_wide = rot_pair << rot_amt;
        case (bus.sel)
            OP_ADD: begin
                res_c   = add_sum[WIDTH-1:0];
                carry_c = add_sum[WIDTH];
                ovf_c   = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                res_c   = sub_diff[WIDTH-1:0];
                carry_c = sub_diff[WIDTH];
                ovf_c   = (bus.a[MSB] != bus.b[MSB]) && (sub_diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  res_c = bus.a & bus.b;
            OP_OR:   res_c = bus.a | bus.b;
            OP_XOR:  res_c = bus.a ^ bus.b;
            OP_NOR:  res_c = ~(bus.a | bus.b);
            OP_NAND: res_c = ~(bus.a & bus.b);
            OP_XNOR: res_c = ~(bus.a ^ bus.b);
            OP_EQU:  res_c = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_GT:   res_c = {{(WIDTH-1){1'b0}}, (bus.a > bus.b)};
            OP_LT:   res_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_ROR:  res_c = ror_wide[WIDTH-1:0];
            OP_ROL:  res_c = rol_wide[2*WIDTH-1:WIDTH];
            OP_MULT: res_c = '0;
            OP_DIV:  err_c = (bus.b == '0);
            OP_MFLO: res_c = lo_q;
            OP_MFHI: res_c = hi_q;
            default: err_c = 1'b1;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide on the work registers.
    always_comb begin
        mul_sum   = work_lo[0] ? ({1'b0, work_hi} + {1'b0, opnd}) : {1'b0, work_hi};
        div_shift = {work_hi, work_lo[MSB]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        step_hi   = '0;
        step_lo   = '0;
        if (state == MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
    end

    // Pick what gets published this edge: a single-cycle op or the last iteration.
    always_comb begin
        publish    = 1'b0;
        pub_result = res_c;
        pub_carry  = carry_c;
        pub_ovf    = ovf_c;
        pub_err    = err_c;
        if (accept && !start_mul && !start_div) begin
            publish = 1'b1;
        end else if ((state == MUL || state == DIV) && last_step) begin
            publish    = 1'b1;
            pub_result = step_lo;
            pub_carry  = (state == MUL) && (step_hi != '0);
            pub_ovf    = 1'b0;
            pub_err    = 1'b0;
        end
    end

    // Iteration registers and HI/LO; operands are frozen here at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            opnd    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start_mul) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= bus.b;
            opnd    <= bus.a;
        end else if (start_div) begin
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= bus.a;
            opnd    <= bus.b;
        end else if (state == MUL || state == DIV) begin
            cnt     <= cnt + 1'b1;
            work_hi <= step_hi;
            work_lo <= step_lo;
            if (last_step) begin
                hi_q <= step_hi;
                lo_q <= step_lo;
            end
        end
    end

    // Result and flag registers hold until the next publish; out_valid pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            out_valid_q <= publish;
            if (publish) begin
                result_q   <= pub_result;
                zero_q     <= (pub_result == '0);
                carry_q    <= pub_carry;
                overflow_q <= pub_ovf;
                error_q    <= pub_err;
            end
        end
    end

`ifdef SEQ_ALU_SEG_DISPLAY_EN
    logic [6:0] seg_q;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            4'hB:    return 7'h7C;
            4'hC:    return 7'h39;
            4'hD:    return 7'h5E;
            4'hE:    return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Segment pattern tracks the low nibble of each published result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '0;
        end else if (publish) begin
            seg_q <= hex_to_seg(pub_result[3:0]);
        end
    end

    assign bus.seg = seg_q;
`else
    assign bus.seg = 7'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = ~in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed examples with literal expectations, then randomized
// traffic, all shadowed by a cycle-level behavioural model of seq_alu.
module tb_seq_alu;

    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int MASK = MOD - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Model-visible state
    bit m_ready = 1'b1;
    bit m_valid = 1'b0;
    bit m_zero  = 1'b0;
    bit m_carry = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_err   = 1'b0;
    bit m_done  = 1'b0;
    int m_result    = 0;
    int m_seg       = 0;
    int m_hi        = 0;
    int m_lo        = 0;
    int m_busy_left = 0;
    int p_hi        = 0;
    int p_lo        = 0;
    bit p_carry     = 1'b0;
    int ma, mb, ms, mr, mp;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int toSigned(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    function automatic bit outOfRange(input int s);
        return (s > MOD / 2 - 1) || (s < -(MOD / 2));
    endfunction

    function automatic int segOf(input int v);
`ifdef SEQ_ALU_SEG_DISPLAY_EN
        case (v & 15)
            0:       return 'h3F;
            1:       return 'h06;
            2:       return 'h5B;
            3:       return 'h4F;
            4:       return 'h66;
            5:       return 'h6D;
            6:       return 'h7D;
            7:       return 'h07;
            8:       return 'h7F;
            9:       return 'h6F;
            10:      return 'h77;
            11:      return 'h7C;
            12:      return 'h39;
            13:      return 'h5E;
            14:      return 'h79;
            default: return 'h71;
        endcase
`else
        return v & 0;
`endif
    endfunction

    task automatic setResult(input int r, input bit c, input bit o, input bit e);
        m_result = r & MASK;
        m_zero   = (m_result == 0);
        m_carry  = c;
        m_ovf    = o;
        m_err    = e;
        m_seg    = segOf(m_result);
        m_valid  = 1'b1;
    endtask

    // Behavioural model: accept when its own notion of ready allows, publish per op latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b1; m_valid = 1'b0; m_done = 1'b0; m_busy_left = 0;
            m_result = 0; m_zero = 1'b0; m_carry = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
            m_seg = 0; m_hi = 0; m_lo = 0;
        end else begin
            m_valid = 1'b0;
            if (m_done) begin
                m_done  = 1'b0;
                m_ready = 1'b1;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    setResult(p_lo, p_carry, 1'b0, 1'b0);
                    m_done = 1'b1;
                end
            end else if (bus.in_valid === 1'b1) begin
                ma = int'(bus.a);
                mb = int'(bus.b);
                ms = int'(bus.sel);
                case (ms)
                    0: begin
                        mr = ma + mb;
                        setResult(mr, mr >= MOD, outOfRange(toSigned(ma) + toSigned(mb)), 1'b0);
                    end
                    1: setResult(ma - mb + MOD, ma < mb, outOfRange(toSigned(ma) - toSigned(mb)), 1'b0);
                    2: setResult(ma & mb, 1'b0, 1'b0, 1'b0);
                    3: setResult(ma | mb, 1'b0, 1'b0, 1'b0);
                    4: setResult(ma ^ mb, 1'b0, 1'b0, 1'b0);
                    5: setResult(~(ma | mb), 1'b0, 1'b0, 1'b0);
                    6: setResult(~(ma & mb), 1'b0, 1'b0, 1'b0);
                    7: setResult(~(ma ^ mb), 1'b0, 1'b0, 1'b0);
                    8: setResult(int'(ma == mb), 1'b0, 1'b0, 1'b0);
                    9: setResult(int'(ma > mb), 1'b0, 1'b0, 1'b0);
                    10: setResult(int'(ma < mb), 1'b0, 1'b0, 1'b0);
                    11: begin
                        mr = ma;
                        for (int k = 0; k < mb % W; k++) mr = (mr >> 1) | ((mr & 1) << (W - 1));
                        setResult(mr, 1'b0, 1'b0, 1'b0);
                    end
                    12: begin
                        mr = ma;
                        for (int k = 0; k < mb % W; k++) mr = ((mr << 1) & MASK) | (mr >> (W - 1));
                        setResult(mr, 1'b0, 1'b0, 1'b0);
                    end
                    13: begin
                        mp = ma * mb;
                        p_lo = mp % MOD;
                        p_hi = mp / MOD;
                        p_carry = (p_hi != 0);
                        m_busy_left = W;
                        m_ready = 1'b0;
                    end
                    14: begin
                        if (mb == 0) begin
                            setResult(0, 1'b0, 1'b0, 1'b1);
                        end else begin
                            p_lo = ma / mb;
                            p_hi = ma % mb;
                            p_carry = 1'b0;
                            m_busy_left = W;
                            m_ready = 1'b0;
                        end
                    end
                    15: setResult(m_lo, 1'b0, 1'b0, 1'b0);
                    16: setResult(m_hi, 1'b0, 1'b0, 1'b0);
                    default: setResult(0, 1'b0, 1'b0, 1'b1);
                endcase
            end
        end
    end

    // Compare every DUT output against the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("in_ready",  bus.in_ready,  32'(m_ready));
            checkOutput("busy",      bus.busy,      32'(!m_ready));
            checkOutput("out_valid", bus.out_valid, 32'(m_valid));
            checkOutput("result",    bus.result,    m_result);
            checkOutput("zero",      bus.zero,      32'(m_zero));
            checkOutput("carry",     bus.carry,     32'(m_carry));
            checkOutput("overflow",  bus.overflow,  32'(m_ovf));
            checkOutput("error",     bus.error,     32'(m_err));
            checkOutput("seg",       bus.seg,       m_seg);
        end
    end

    // Issue one op while idle and wait (bounded) for its out_valid pulse.
    task automatic applyStimulus(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                 input logic [4:0] sel_in, input string tag, output int lat);
        lat = -1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = a_in;
        bus.b        = b_in;
        bus.sel      = sel_in;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_completed"}, 32'(lat > 0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic [4:0]   rs;

        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sel      = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("reset_in_ready",  bus.in_ready,  1);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_result",    bus.result,    0);
        checkOutput("reset_flags",     {bus.zero, bus.carry, bus.overflow, bus.error}, 0);
        checkOutput("reset_seg",       bus.seg,       0);
        rst      = 1'b0;
        check_en = 1'b1;

        applyStimulus(4'h7, 4'h1, 5'h00, "add", lat);
        checkOutput("add_latency",  lat, 1);
        checkOutput("add_result",   bus.result, 4'h8);
        checkOutput("add_overflow", bus.overflow, 1);
        checkOutput("add_carry",    bus.carry, 0);
        checkOutput("add_zero",     bus.zero, 0);
        checkOutput("model_add",    m_result, 8);

        applyStimulus(4'h3, 4'h5, 5'h01, "sub1", lat);
        checkOutput("sub1_result",   bus.result, 4'hE);
        checkOutput("sub1_carry",    bus.carry, 1);
        checkOutput("sub1_overflow", bus.overflow, 0);
        applyStimulus(4'h8, 4'h1, 5'h01, "sub2", lat);
        checkOutput("sub2_result",   bus.result, 4'h7);
        checkOutput("sub2_overflow", bus.overflow, 1);

        applyStimulus(4'hF, 4'hF, 5'h0D, "mult", lat);
        checkOutput("mult_latency", lat, 5);
        checkOutput("mult_result",  bus.result, 4'h1);
        checkOutput("mult_carry",   bus.carry, 1);
        checkOutput("mult_ready_in_done", bus.in_ready, 0);
        checkOutput("model_mult_hi", m_hi, 14);
        applyStimulus(4'h0, 4'h0, 5'h10, "mfhi1", lat);
        checkOutput("mfhi1_latency", lat, 1);
        checkOutput("mfhi1_result",  bus.result, 4'hE);

        applyStimulus(4'hD, 4'h4, 5'h0E, "div", lat);
        checkOutput("div_latency", lat, 5);
        checkOutput("div_result",  bus.result, 4'h3);
        applyStimulus(4'h0, 4'h0, 5'h10, "mfhi2", lat);
        checkOutput("mfhi2_result", bus.result, 4'h1);
        applyStimulus(4'h5, 4'h0, 5'h0E, "div0", lat);
        checkOutput("div0_latency", lat, 1);
        checkOutput("div0_error",   bus.error, 1);
        checkOutput("div0_result",  bus.result, 0);
        checkOutput("div0_zero",    bus.zero, 1);
        applyStimulus(4'h0, 4'h0, 5'h0F, "mflo", lat);
        checkOutput("mflo_result", bus.result, 4'h3);
        checkOutput("mflo_error",  bus.error, 0);

        applyStimulus(4'b0001, 4'h5, 5'h0C, "rol", lat);
        checkOutput("rol_result", bus.result, 4'b0010);
        applyStimulus(4'b0001, 4'h4, 5'h0B, "ror_amt0", lat);
        checkOutput("ror_amt0_result", bus.result, 4'b0001);
        applyStimulus(4'h9, 4'h3, 5'h1F, "invalid", lat);
        checkOutput("invalid_error", bus.error, 1);
        checkOutput("invalid_zero",  bus.zero, 1);

        // Abandon a multiply partway through with an asynchronous reset.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 4'hF;
        bus.b        = 4'hF;
        bus.sel      = 5'h0D;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midmult_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_in_ready",  bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            checkOutput("rst_no_out_valid", bus.out_valid, 0);
        end
        applyStimulus(4'h0, 4'h0, 5'h10, "rst_mfhi", lat);
        checkOutput("rst_mfhi_result", bus.result, 0);
        applyStimulus(4'h0, 4'h0, 5'h0F, "rst_mflo", lat);
        checkOutput("rst_mflo_result", bus.result, 0);

        // Randomized traffic; in_valid is held arbitrarily, including while busy.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ra = W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            rs = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.a        = ra;
            bus.b        = rb;
            bus.sel      = rs;
            if (i == 400) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
